biss_frame_check: RTL and testbench

Downstream stage of the BiSS-C master receiver. It takes the bit-serial payload the master samples on each MA period after the start bit, and de-frames it into CDS, position, nE and nW fields. It checks the CRC-6 (polynomial x^6+x+1, init 0, transmitted inverted, MSB first) and presents a registered, validated position word with status pulses and saturating frame statistics to the position consumer.

---
 rtl/biss_frame_check_if.sv | 27 ++
 rtl/biss_frame_check.sv | 169 ++++++++++++++++
 tb/tb_biss_frame_check.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/biss_frame_check_if.sv
// Bit-stream and result bundle between the BiSS-C sampler, the frame checker and the position consumer.
interface biss_frame_check_if #(
    parameter int POS_W = 26
);
    logic             frame_start;
    logic             bit_valid;
    logic             bit_data;
    logic [POS_W-1:0] pos_data;
    logic             err_n;
    logic             warn_n;
    logic             data_valid;
    logic             crc_err;
    logic             len_err;
    logic             busy;
    logic [15:0]      good_cnt;
    logic [15:0]      bad_cnt;

    modport master (
        output frame_start, bit_valid, bit_data,
        input  pos_data, err_n, warn_n, data_valid, crc_err, len_err, busy, good_cnt, bad_cnt
    );

    modport slave (
        input  frame_start, bit_valid, bit_data,
        output pos_data, err_n, warn_n, data_valid, crc_err, len_err, busy, good_cnt, bad_cnt
    );
endinterface

// File: rtl/biss_frame_check.sv
// BiSS-C frame de-framer: splits CDS/position/nE/nW fields, checks the inverted CRC-6,
// and publishes a validated position word plus status pulses and saturating frame statistics.
module biss_frame_check #(
    parameter int POS_W       = 26,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic              clk,
    input  logic              rst,
    biss_frame_check_if.slave bus
);
    localparam int DATA_BITS = POS_W + 2;
    localparam int CNT_W     = $clog2(DATA_BITS + 6);
    localparam int TMO_W     = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, CDS, DATA, CRC, CHECK} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [5:0]           crc_q, crc_d;
    logic [5:0]           rx_crc_q, rx_crc_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 err_n_q, err_n_d;
    logic                 warn_n_q, warn_n_d;
    logic                 data_valid_q, data_valid_d;
    logic                 crc_err_q, crc_err_d;
    logic                 len_err_q, len_err_d;
    logic                 busy_q, busy_d;
    logic [15:0]          good_cnt_q, good_cnt_d;
    logic [15:0]          bad_cnt_q, bad_cnt_d;
    logic                 good_inc, bad_inc, fb;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        shift_d      = shift_q;
        crc_d        = crc_q;
        rx_crc_d     = rx_crc_q;
        pos_d        = pos_q;
        err_n_d      = err_n_q;
        warn_n_d     = warn_n_q;
        busy_d       = busy_q;
        data_valid_d = 1'b0;
        crc_err_d    = 1'b0;
        len_err_d    = 1'b0;
        good_inc     = 1'b0;
        bad_inc      = 1'b0;
        fb           = crc_q[5] ^ bus.bit_data;

        case (state_q)
            IDLE: begin
                if (bus.frame_start) begin
                    state_d  = CDS;
                    cnt_d    = '0;
                    tmo_d    = '0;
                    shift_d  = '0;
                    crc_d    = '0;
                    rx_crc_d = '0;
                    busy_d   = 1'b1;
                end
            end
            CHECK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (rx_crc_q == ~crc_q) begin
                    pos_d        = shift_q[POS_W+1:2];
                    err_n_d      = shift_q[1];
                    warn_n_d     = shift_q[0];
                    data_valid_d = 1'b1;
                    good_inc     = 1'b1;
                end else begin
                    crc_err_d = 1'b1;
                    bad_inc   = 1'b1;
                end
            end
            default: begin
                // A new start bit mid-frame wins over any bit strobe in the same cycle.
                if (bus.frame_start) begin
                    len_err_d = 1'b1;
                    bad_inc   = 1'b1;
                    state_d   = CDS;
                    cnt_d     = '0;
                    tmo_d     = '0;
                    shift_d   = '0;
                    crc_d     = '0;
                    rx_crc_d  = '0;
                end else if (bus.bit_valid) begin
                    tmo_d = '0;
                    if (state_q == CDS) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end else if (state_q == DATA) begin
                        shift_d = {shift_q[DATA_BITS-2:0], bus.bit_data};
                        crc_d   = {crc_q[4:0], 1'b0} ^ (fb ? 6'b000011 : 6'b000000);
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                            state_d = CRC;
                            cnt_d   = '0;
                        end
                    end else begin
                        rx_crc_d = {rx_crc_q[4:0], bus.bit_data};
                        cnt_d    = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(5)) begin
                            state_d = CHECK;
                        end
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    len_err_d = 1'b1;
                    bad_inc   = 1'b1;
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase

        good_cnt_d = (good_inc && good_cnt_q != 16'hFFFF) ? good_cnt_q + 16'd1 : good_cnt_q;
        bad_cnt_d  = (bad_inc && bad_cnt_q != 16'hFFFF) ? bad_cnt_q + 16'd1 : bad_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tmo_q        <= '0;
            shift_q      <= '0;
            crc_q        <= '0;
            rx_crc_q     <= '0;
            pos_q        <= '0;
            err_n_q      <= 1'b1;
            warn_n_q     <= 1'b1;
            data_valid_q <= 1'b0;
            crc_err_q    <= 1'b0;
            len_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            good_cnt_q   <= '0;
            bad_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            shift_q      <= shift_d;
            crc_q        <= crc_d;
            rx_crc_q     <= rx_crc_d;
            pos_q        <= pos_d;
            err_n_q      <= err_n_d;
            warn_n_q     <= warn_n_d;
            data_valid_q <= data_valid_d;
            crc_err_q    <= crc_err_d;
            len_err_q    <= len_err_d;
            busy_q       <= busy_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
        end
    end

    assign bus.pos_data   = pos_q;
    assign bus.err_n      = err_n_q;
    assign bus.warn_n     = warn_n_q;
    assign bus.data_valid = data_valid_q;
    assign bus.crc_err    = crc_err_q;
    assign bus.len_err    = len_err_q;
    assign bus.busy       = busy_q;
    assign bus.good_cnt   = good_cnt_q;
    assign bus.bad_cnt    = bad_cnt_q;
endmodule

// File: tb/tb_biss_frame_check.sv
// Self-checking bench for biss_frame_check: fixed vectors, random frames against a
// polynomial-division CRC model, and hand-built timeout/restart/saturation/reset sequences.
module tb_biss_frame_check;
    localparam int POS_W       = 26;
    localparam int TIMEOUT_CYC = 200;

    typedef struct {
        logic             cds;
        logic [POS_W-1:0] pos;
        logic             ne;
        logic             nw;
        logic [5:0]       crc_tx;
        logic             exp_dv;
        logic [POS_W-1:0] exp_pos;
        logic             exp_err_n;
        logic             exp_warn_n;
        logic [15:0]      exp_good;
        logic [15:0]      exp_bad;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [POS_W-1:0] m_pos;
    logic             m_err_n;
    logic             m_warn_n;
    logic [15:0]      m_good;
    logic [15:0]      m_bad;

    biss_frame_check_if #(.POS_W(POS_W)) bus ();

    biss_frame_check #(
        .POS_W      (POS_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC as the remainder of msg(x)*x^6 divided by x^6+x+1 (init 0 makes this equivalent).
    function automatic logic [5:0] model_crc(input logic [POS_W+1:0] msg);
        logic [POS_W+7:0] r;
        r = {msg, 6'b000000};
        for (int i = POS_W + 7; i >= 6; i--) begin
            if (r[i]) r[i -: 7] = r[i -: 7] ^ 7'b1000011;
        end
        return r[5:0];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic start_frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) tick();
        bus.bit_valid = 1'b1;
        bus.bit_data  = b;
        tick();
        bus.bit_valid = 1'b0;
        bus.bit_data  = 1'b0;
    endtask

    task automatic send_body(input logic cds, input logic [POS_W-1:0] pos, input logic ne,
                             input logic nw, input logic [5:0] crc_tx, input int gap_max);
        logic [POS_W+8:0] frame;
        frame = {cds, pos, ne, nw, crc_tx};
        for (int i = POS_W + 8; i >= 0; i--) begin
            send_bit(frame[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
    endtask

    task automatic apply_stimulus(input logic cds, input logic [POS_W-1:0] pos, input logic ne,
                                  input logic nw, input logic [5:0] crc_tx, input int gap_max);
        start_frame();
        send_body(cds, pos, ne, nw, crc_tx, gap_max);
    endtask

    // Called one cycle after the last CRC bit; the resolution pulse is due on the next cycle.
    task automatic finish_frame(input logic exp_dv);
        check_output("no_early_pulse", {29'd0, bus.data_valid, bus.crc_err, bus.len_err}, 32'd0);
        check_output("busy_in_check", bus.busy, 1'b1);
        tick();
        check_output("data_valid", bus.data_valid, exp_dv);
        check_output("crc_err", bus.crc_err, !exp_dv);
        check_output("len_err_quiet", bus.len_err, 1'b0);
        check_output("busy_done", bus.busy, 1'b0);
        check_output("pos_data", bus.pos_data, m_pos);
        check_output("err_n", bus.err_n, m_err_n);
        check_output("warn_n", bus.warn_n, m_warn_n);
        check_output("good_cnt", bus.good_cnt, m_good);
        check_output("bad_cnt", bus.bad_cnt, m_bad);
        tick();
        check_output("pulse_single", {30'd0, bus.data_valid, bus.crc_err}, 32'd0);
    endtask

    task automatic model_frame(input logic [POS_W-1:0] pos, input logic ne, input logic nw,
                               input logic [5:0] crc_tx, output logic ok);
        ok = (crc_tx == ~model_crc({pos, ne, nw}));
        if (ok) begin
            m_pos    = pos;
            m_err_n  = ne;
            m_warn_n = nw;
            m_good   = sat_inc(m_good);
        end else begin
            m_bad = sat_inc(m_bad);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_pos"}, bus.pos_data, 0);
        check_output({tag, "_flags"}, {26'd0, bus.err_n, bus.warn_n, bus.data_valid,
                                      bus.crc_err, bus.len_err, bus.busy}, 32'b110000);
        check_output({tag, "_good"}, bus.good_cnt, 0);
        check_output({tag, "_bad"}, bus.bad_cnt, 0);
    endtask

    vec_t vecs[5];

    initial begin
        logic ok;
        logic early;
        logic [POS_W-1:0] rpos;
        logic rne, rnw, rcds;
        logic [5:0] tx;

        vecs[0] = '{1'b0, 26'd0, 1'b0, 1'b0, 6'b111111, 1'b1, 26'd0, 1'b0, 1'b0, 16'd1, 16'd0};
        vecs[1] = '{1'b0, 26'd0, 1'b0, 1'b1, 6'b111100, 1'b1, 26'd0, 1'b0, 1'b1, 16'd2, 16'd0};
        vecs[2] = '{1'b0, 26'd0, 1'b1, 1'b0, 6'b111001, 1'b1, 26'd0, 1'b1, 1'b0, 16'd3, 16'd0};
        vecs[3] = '{1'b0, 26'd0, 1'b0, 1'b0, 6'b111110, 1'b0, 26'd0, 1'b1, 1'b0, 16'd3, 16'd1};
        vecs[4] = '{1'b1, 26'd1, 1'b1, 1'b1, 6'b110110, 1'b1, 26'd1, 1'b1, 1'b1, 16'd4, 16'd1};

        bus.frame_start = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.bit_data    = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i].cds, vecs[i].pos, vecs[i].ne, vecs[i].nw, vecs[i].crc_tx, i);
            m_pos    = vecs[i].exp_pos;
            m_err_n  = vecs[i].exp_err_n;
            m_warn_n = vecs[i].exp_warn_n;
            m_good   = vecs[i].exp_good;
            m_bad    = vecs[i].exp_bad;
            finish_frame(vecs[i].exp_dv);
        end

        for (int i = 0; i < 24; i++) begin
            rcds = 1'($urandom);
            rpos = POS_W'($urandom);
            rne  = 1'($urandom);
            rnw  = 1'($urandom);
            tx   = ~model_crc({rpos, rne, rnw});
            if ($urandom_range(0, 3) == 0) tx = tx ^ (6'd1 << $urandom_range(0, 5));
            apply_stimulus(rcds, rpos, rne, rnw, tx, 3);
            model_frame(rpos, rne, rnw, tx, ok);
            finish_frame(ok);
        end

        // Timeout: 10 bits, then silence until the abort.
        start_frame();
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 0);
        early = 1'b0;
        for (int i = 0; i < TIMEOUT_CYC; i++) begin
            if (bus.len_err || !bus.busy) early = 1'b1;
            tick();
        end
        m_bad = sat_inc(m_bad);
        check_output("tmo_no_early", early, 1'b0);
        check_output("tmo_len_err", bus.len_err, 1'b1);
        check_output("tmo_busy", bus.busy, 1'b0);
        check_output("tmo_bad_cnt", bus.bad_cnt, m_bad);
        check_output("tmo_pos_kept", bus.pos_data, m_pos);
        tick();
        check_output("tmo_pulse_single", bus.len_err, 1'b0);
        send_bit(1'b1, 2);
        check_output("idle_ignores_bits", bus.busy, 1'b0);

        // Early restart after 20 bits, then a valid all-zero frame.
        start_frame();
        for (int i = 0; i < 20; i++) send_bit(1'($urandom), 1);
        start_frame();
        m_bad = sat_inc(m_bad);
        check_output("restart_len_err", bus.len_err, 1'b1);
        check_output("restart_busy", bus.busy, 1'b1);
        check_output("restart_bad_cnt", bus.bad_cnt, m_bad);
        send_body(1'b0, '0, 1'b0, 1'b0, 6'b111111, 0);
        model_frame('0, 1'b0, 1'b0, 6'b111111, ok);
        finish_frame(ok);

        // Saturation of the good-frame counter.
        force dut.good_cnt_q = 16'hFFFF;
        tick();
        release dut.good_cnt_q;
        tick();
        m_good = 16'hFFFF;
        check_output("sat_preload", bus.good_cnt, 16'hFFFF);
        apply_stimulus(1'b0, 26'd1, 1'b1, 1'b1, 6'b110110, 1);
        model_frame(26'd1, 1'b1, 1'b1, 6'b110110, ok);
        finish_frame(ok);

        // Asynchronous reset mid-frame.
        start_frame();
        for (int i = 0; i < 8; i++) send_bit(1'($urandom), 0);
        #3 rst = 1'b0;
        #2;
        check_reset_values("midreset");
        rst = 1'b1;
        tick();
        check_reset_values("postreset");
        m_pos    = '0;
        m_err_n  = 1'b1;
        m_warn_n = 1'b1;
        m_good   = '0;
        m_bad    = '0;
        rpos = POS_W'($urandom);
        tx   = ~model_crc({rpos, 2'b10});
        apply_stimulus(1'b1, rpos, 1'b1, 1'b0, tx, 2);
        model_frame(rpos, 1'b1, 1'b0, tx, ok);
        finish_frame(ok);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
